calc_port_arbiter: RTL and testbench
====================================

Name: calc_port_arbiter

Overview:
- Front-end scheduler that shares one calculator ALU between four requester ports.
- Each port uses the two-cycle request protocol:
  - cycle 1: command plus operand 1;
  - cycle 2: operand 2.
- Captures complete requests per port, grants the ALU round-robin, tags each issue with its port number, and routes each tagged ALU result back to the owning port as a one-cycle response.
- Sits between the four external request ports and the shared add/sub/shift datapath.

Parameters:
- NPORTS, 4, number of requester ports (fixed at 4; tag width 2).
- DW, 32, operand/result width.
- TIMEOUT_CYCLES, 16, ALU response watchdog limit (used only with the optional feature).

Ports:
- c_clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- reqN_cmd_in  in  4  (N=1..4) command: 0 nop, 1 add, 2 sub, 5 shl, 6 shr; others invalid.
- reqN_data_in  in  DW  (N=1..4) operand 1 in the command cycle, operand 2 in the next cycle.
- out_dataN  out  DW  (N=1..4) result, valid only while out_respN != 0.
- out_respN  out  2  (N=1..4) 0 none, 1 success, 2 overflow/underflow/invalid, 3 timeout.
- alu_req_valid  out  1  issue request to ALU.
- alu_req_ready  in  1  ALU accepts when valid&&ready at an edge.
- alu_req_cmd  out  4  issued command.
- alu_req_op1, alu_req_op2  out  DW  issued operands.
- alu_req_tag  out  2  issuing port (0..3 = port 1..4).
- alu_rsp_valid  in  1  ALU result strobe.
- alu_rsp_tag  in  2  port the result belongs to.
- alu_rsp_resp  in  2  ALU response code (1 or 2).
- alu_rsp_data  in  DW  ALU result.
- port_busy  out  4  bit N-1 high while port N holds a request.

Behaviour:
- Reset: every port goes to IDLE.
  - out_dataN=0, out_respN=0, alu_req_valid=0, alu_req_*=0, port_busy=0.
  - Round-robin pointer resets to port 1.
  - Reset mid-operation discards all in-flight requests. ALU responses arriving afterwards find no ISSUED port and are ignored.
- Per-port FSM:
  - IDLE -> OP2 on an edge with cmd!=0. Latch cmd and operand 1.
  - OP2 -> next edge: latch operand 2 unconditionally. Valid cmd -> PEND; invalid cmd -> RESP with resp=2, data=0; the ALU is never used.
  - PEND -> ISSUED at the edge where the port is granted and alu_req_valid&&alu_req_ready.
  - ISSUED -> RESP at the edge where alu_rsp_valid && alu_rsp_tag==port. Latch resp and data.
  - RESP: out_respN/out_dataN driven for exactly one cycle, then IDLE.
- port_busy[N-1] is 1 in OP2, PEND, ISSUED and RESP.
- Commands arriving while a port is not IDLE are ignored; the protocol forbids them.
- Arbitration:
  - Combinational round-robin over PEND ports, starting at the pointer.
  - Issue registers are loaded from the winner; alu_req_valid is registered.
  - Once alu_req_valid is high, valid, cmd, ops and tag are held stable until accepted. No re-arbitration occurs while unaccepted.
  - On acceptance the pointer moves to the port after the winner.
  - At most one issue per cycle.
- Latency with an idle ALU and no contention:
  - cmd sampled at E0, op2 at E1, alu_req_valid high after E1.
  - Accepted at E2.
  - With a 1-cycle ALU, the response strobe is sampled at E3 and out_respN is high between E3 and E4.
  - Minimum 4 edges from command to response.
- Boundary rules:
  - A response for a port can coincide with a new issue, and with that port's next command sampling at the edge after RESP.
  - alu_rsp_valid with a tag whose port is not ISSUED is dropped.
  - Invalid-command responses on one port and ALU responses on another in the same cycle are independent.
  - All four ports pending: grants are issued in pointer order, no port starves; worst wait is 3 issues.

Optional Feature:
- CALC_ARB_TIMEOUT_EN defined:
  - Each port in ISSUED counts cycles from acceptance.
  - Reaching TIMEOUT_CYCLES with no matching response: port goes to RESP with resp=3, data=0.
  - A later stale response with that tag is dropped, unless the port has since re-issued. Stale-response protection is provided by a per-port 1-bit sequence number carried in a 3-bit alu_req_tag/alu_rsp_tag (the MSB is the sequence bit).
- Undefined: no counters; tags are 2 bits; a port waits indefinitely.

Decomposition:
- Package calc_arb_pkg:
  - command codes (CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6);
  - response codes (RESP_NONE, RESP_OK, RESP_ERR, RESP_TMO);
  - port FSM state enum;
  - function is_valid_cmd.
- One sub-module, calc_arb_port: per-port FSM, operand capture, response register and optional watchdog, instantiated 4 times.
- The top level holds the round-robin arbiter, issue registers and tag demux.

Test Plan:
- Port 1 sends add 0x1 then 0x1FFFFFF; ALU is a 1-cycle model -> alu_req_cmd=1, op1=1, op2=0x1FFFFFF, tag=0; out_resp1=1, out_data1=0x2000000 for one cycle, 4 edges after the command.
- All 4 ports send add in the same cycle, with alu_req_ready held high -> issues in tag order 0,1,2,3 on consecutive edges; each port gets exactly one response; pointer ends at port 1.
- Port 3 sends cmd 3, then cmd 4 -> no alu_req_valid; out_resp3=2, out_data3=0 two edges after each command.
- alu_req_ready held low for 5 cycles with port 2 pending -> valid, ops and tag held constant; single acceptance; exactly one response.
- Reset asserted while port 4 is ISSUED; ALU then returns tag 3 -> all outputs 0 during reset; returned response ignored; out_resp4 stays 0.
- With CALC_ARB_TIMEOUT_EN: ALU never responds to port 1 -> out_resp1=3 exactly TIMEOUT_CYCLES=16 cycles after acceptance; a later stale tag-0 response is dropped.

Source files
------------

// File: rtl/calc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_arb_pkg
// Purpose  : Shared command/response codes, port FSM states and helpers for
//            the calculator port arbiter.
// Options  : CALC_ARB_TIMEOUT_EN widens the ALU tag by one sequence bit.
// Revision : 1.0 - initial release
// ============================================================================
package calc_arb_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;
  localparam logic [1:0] RESP_TMO  = 2'd3;

  // Tag = {sequence bit, port index} when the watchdog is built in.
`ifdef CALC_ARB_TIMEOUT_EN
  localparam int TW = 3;
`else
  localparam int TW = 2;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OP2    = 3'd1,
    ST_PEND   = 3'd2,
    ST_ISSUED = 3'd3,
    ST_RESP   = 3'd4
  } port_state_e;

  function automatic logic is_valid_cmd(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_arb_port.sv
`default_nettype none
// ============================================================================
// Module   : calc_arb_port
// Purpose  : One requester port: two-cycle request capture, pending/issued
//            tracking, one-cycle response register and optional watchdog.
// Options  : CALC_ARB_TIMEOUT_EN adds the ISSUED-state watchdog and the
//            per-port sequence bit.
// Revision : 1.0 - initial release
// ============================================================================
module calc_arb_port
  import calc_arb_pkg::*;
#(
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [3:0]    cmd_i,
  input  logic [DW-1:0] data_i,
  input  logic          grant_i,
  input  logic          rsp_hit_i,
  input  logic [1:0]    rsp_resp_i,
  input  logic [DW-1:0] rsp_data_i,
  output logic          pend_o,
  output logic          busy_o,
`ifdef CALC_ARB_TIMEOUT_EN
  output logic          seq_o,
`endif
  output logic [3:0]    cmd_o,
  output logic [DW-1:0] op1_o,
  output logic [DW-1:0] op2_o,
  output logic [1:0]    resp_o,
  output logic [DW-1:0] data_o
);

  port_state_e   state_q, state_d;
  logic [3:0]    cmd_q;
  logic [DW-1:0] op1_q;
  logic [DW-1:0] op2_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    resp_q;
  logic          w_tmo;

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          seq_q;

  // Counter holds cycles spent in ISSUED; the limit edge is the TIMEOUT_CYCLES-th after acceptance.
  assign w_tmo = (state_q == ST_ISSUED) && !rsp_hit_i &&
                 (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign seq_o = seq_q;

  // Watchdog counter and sequence bit; the bit flips whenever an issue completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      seq_q <= 1'b0;
    end else begin
      if (state_q == ST_PEND && grant_i) begin
        cnt_q <= '0;
      end else if (state_q == ST_ISSUED) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == ST_ISSUED && state_d == ST_RESP) begin
        seq_q <= ~seq_q;
      end
    end
  end
`else
  // Without the watchdog a port waits for its ALU result indefinitely.
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a matching ALU result takes priority over a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_i != CMD_NOP) state_d = ST_OP2;
      ST_OP2:    state_d = is_valid_cmd(cmd_q) ? ST_PEND : ST_RESP;
      ST_PEND:   if (grant_i) state_d = ST_ISSUED;
      ST_ISSUED: if (rsp_hit_i || w_tmo) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Operand capture and response latch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
      resp_q  <= RESP_NONE;
      rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cmd_i != CMD_NOP) begin
        cmd_q <= cmd_i;
        op1_q <= data_i;
      end
      if (state_q == ST_OP2) begin
        op2_q <= data_i;
        if (!is_valid_cmd(cmd_q)) begin
          resp_q  <= RESP_ERR;
          rdata_q <= '0;
        end
      end
      if (state_q == ST_ISSUED) begin
        if (rsp_hit_i) begin
          resp_q  <= rsp_resp_i;
          rdata_q <= rsp_data_i;
        end else if (w_tmo) begin
          resp_q  <= RESP_TMO;
          rdata_q <= '0;
        end
      end
    end
  end

  // Outputs; a valid request in OP2 already bids so the issue register can
  // load it on the same edge that operand 2 is captured.
  always_comb begin
    pend_o = (state_q == ST_PEND) || (state_q == ST_OP2 && is_valid_cmd(cmd_q));
    busy_o = (state_q != ST_IDLE);
    op2_o  = (state_q == ST_OP2) ? data_i : op2_q;
    resp_o = RESP_NONE;
    data_o = '0;
    if (state_q == ST_RESP) begin
      resp_o = resp_q;
      data_o = rdata_q;
    end
  end

  assign cmd_o = cmd_q;
  assign op1_o = op1_q;

endmodule
`default_nettype wire

// File: rtl/calc_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : calc_port_arbiter
// Purpose  : Shares one calculator ALU between four two-cycle request ports:
//            round-robin grant, tagged issue register, response demux.
// Options  : CALC_ARB_TIMEOUT_EN enables per-port ALU watchdogs and a 3-bit
//            tag whose MSB is the port sequence bit.
// Revision : 1.0 - initial release
// ============================================================================
module calc_port_arbiter
  import calc_arb_pkg::*;
#(
  parameter int NPORTS         = 4,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic [3:0]    req1_cmd_in,
  input  logic [3:0]    req2_cmd_in,
  input  logic [3:0]    req3_cmd_in,
  input  logic [3:0]    req4_cmd_in,
  input  logic [DW-1:0] req1_data_in,
  input  logic [DW-1:0] req2_data_in,
  input  logic [DW-1:0] req3_data_in,
  input  logic [DW-1:0] req4_data_in,
  output logic [DW-1:0] out_data1,
  output logic [DW-1:0] out_data2,
  output logic [DW-1:0] out_data3,
  output logic [DW-1:0] out_data4,
  output logic [1:0]    out_resp1,
  output logic [1:0]    out_resp2,
  output logic [1:0]    out_resp3,
  output logic [1:0]    out_resp4,
  output logic          alu_req_valid,
  input  logic          alu_req_ready,
  output logic [3:0]    alu_req_cmd,
  output logic [DW-1:0] alu_req_op1,
  output logic [DW-1:0] alu_req_op2,
  output logic [TW-1:0] alu_req_tag,
  input  logic          alu_rsp_valid,
  input  logic [TW-1:0] alu_rsp_tag,
  input  logic [1:0]    alu_rsp_resp,
  input  logic [DW-1:0] alu_rsp_data,
  output logic [3:0]    port_busy
);

  logic [3:0]        w_req_cmd [NPORTS];
  logic [DW-1:0]     w_req_data[NPORTS];
  logic [3:0]        w_p_cmd   [NPORTS];
  logic [DW-1:0]     w_p_op1   [NPORTS];
  logic [DW-1:0]     w_p_op2   [NPORTS];
  logic [1:0]        w_p_resp  [NPORTS];
  logic [DW-1:0]     w_p_data  [NPORTS];
  logic [NPORTS-1:0] w_pend, w_busy, w_grant, w_rsp_hit;
`ifdef CALC_ARB_TIMEOUT_EN
  logic [NPORTS-1:0] w_seq;
`endif

  logic              iss_valid_q, iss_valid_d;
  logic [3:0]        iss_cmd_q, iss_cmd_d;
  logic [DW-1:0]     iss_op1_q, iss_op1_d;
  logic [DW-1:0]     iss_op2_q, iss_op2_d;
  logic [TW-1:0]     iss_tag_q, iss_tag_d;
  logic [1:0]        ptr_q, ptr_d;

  logic              w_accept;
  logic [NPORTS-1:0] w_cand;
  logic [1:0]        w_win, w_idx;
  logic              w_found;

  assign w_req_cmd[0]  = req1_cmd_in;
  assign w_req_cmd[1]  = req2_cmd_in;
  assign w_req_cmd[2]  = req3_cmd_in;
  assign w_req_cmd[3]  = req4_cmd_in;
  assign w_req_data[0] = req1_data_in;
  assign w_req_data[1] = req2_data_in;
  assign w_req_data[2] = req3_data_in;
  assign w_req_data[3] = req4_data_in;

  assign w_accept = iss_valid_q && alu_req_ready;

  generate
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      assign w_grant[p] = w_accept && (iss_tag_q[1:0] == 2'(p));
`ifdef CALC_ARB_TIMEOUT_EN
      assign w_rsp_hit[p] = alu_rsp_valid && (alu_rsp_tag[1:0] == 2'(p)) &&
                            (alu_rsp_tag[2] == w_seq[p]);
`else
      assign w_rsp_hit[p] = alu_rsp_valid && (alu_rsp_tag[1:0] == 2'(p));
`endif

      calc_arb_port #(
        .DW             (DW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_port (
        .clk_i      (c_clk),
        .rst_i      (reset),
        .cmd_i      (w_req_cmd[p]),
        .data_i     (w_req_data[p]),
        .grant_i    (w_grant[p]),
        .rsp_hit_i  (w_rsp_hit[p]),
        .rsp_resp_i (alu_rsp_resp),
        .rsp_data_i (alu_rsp_data),
        .pend_o     (w_pend[p]),
        .busy_o     (w_busy[p]),
`ifdef CALC_ARB_TIMEOUT_EN
        .seq_o      (w_seq[p]),
`endif
        .cmd_o      (w_p_cmd[p]),
        .op1_o      (w_p_op1[p]),
        .op2_o      (w_p_op2[p]),
        .resp_o     (w_p_resp[p]),
        .data_o     (w_p_data[p])
      );
    end
  endgenerate

  // Round-robin search from the pointer; the port being accepted this edge is excluded.
  always_comb begin
    ptr_d  = ptr_q;
    w_cand = w_pend;
    if (w_accept) begin
      ptr_d  = iss_tag_q[1:0] + 2'd1;
      w_cand = w_pend & ~w_grant;
    end
    w_found = 1'b0;
    w_win   = ptr_d;
    w_idx   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      w_idx = ptr_d + 2'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Issue register reload: only when empty or being accepted, so an unaccepted request stays frozen.
  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_cmd_d   = iss_cmd_q;
    iss_op1_d   = iss_op1_q;
    iss_op2_d   = iss_op2_q;
    iss_tag_d   = iss_tag_q;
    if (!iss_valid_q || w_accept) begin
      iss_valid_d = w_found;
      iss_cmd_d   = w_found ? w_p_cmd[w_win] : CMD_NOP;
      iss_op1_d   = w_found ? w_p_op1[w_win] : '0;
      iss_op2_d   = w_found ? w_p_op2[w_win] : '0;
`ifdef CALC_ARB_TIMEOUT_EN
      iss_tag_d   = w_found ? {w_seq[w_win], w_win} : '0;
`else
      iss_tag_d   = w_found ? w_win : '0;
`endif
    end
  end

  // Issue registers and round-robin pointer.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      iss_valid_q <= 1'b0;
      iss_cmd_q   <= CMD_NOP;
      iss_op1_q   <= '0;
      iss_op2_q   <= '0;
      iss_tag_q   <= '0;
      ptr_q       <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_cmd_q   <= iss_cmd_d;
      iss_op1_q   <= iss_op1_d;
      iss_op2_q   <= iss_op2_d;
      iss_tag_q   <= iss_tag_d;
      ptr_q       <= ptr_d;
    end
  end

  assign alu_req_valid = iss_valid_q;
  assign alu_req_cmd   = iss_cmd_q;
  assign alu_req_op1   = iss_op1_q;
  assign alu_req_op2   = iss_op2_q;
  assign alu_req_tag   = iss_tag_q;

  assign out_data1 = w_p_data[0];
  assign out_data2 = w_p_data[1];
  assign out_data3 = w_p_data[2];
  assign out_data4 = w_p_data[3];
  assign out_resp1 = w_p_resp[0];
  assign out_resp2 = w_p_resp[1];
  assign out_resp3 = w_p_resp[2];
  assign out_resp4 = w_p_resp[3];
  assign port_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_calc_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_port_arbiter
// Purpose  : Self-checking bench for calc_port_arbiter with a 1-cycle ALU
//            model and issue/response scoreboards.
// Options  : CALC_ARB_TIMEOUT_EN adds the watchdog scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_port_arbiter;
  import calc_arb_pkg::*;

  localparam int DW = 32;

  logic          c_clk = 1'b0;
  logic          reset;
  logic [3:0]    cmd_in  [4];
  logic [DW-1:0] data_in [4];
  logic [DW-1:0] out_data[4];
  logic [1:0]    out_resp[4];
  logic          alu_req_valid, alu_req_ready;
  logic [3:0]    alu_req_cmd;
  logic [DW-1:0] alu_req_op1, alu_req_op2;
  logic [TW-1:0] alu_req_tag;
  logic          alu_rsp_valid;
  logic [TW-1:0] alu_rsp_tag;
  logic [1:0]    alu_rsp_resp;
  logic [DW-1:0] alu_rsp_data;
  logic [3:0]    port_busy;

  // ALU model controls (written by stimulus only)
  logic          alu_en;
  logic          inj_valid;
  logic [TW-1:0] inj_tag;
  logic [DW-1:0] inj_data;

  typedef struct {
    int         port;
    logic [1:0] resp;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [3:0]    cmd;
    logic [31:0]   op1;
    logic [31:0]   op2;
    logic [TW-1:0] tag;
  } iss_t;

  rsp_t rsp_q[$];
  iss_t iss_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 c_clk = ~c_clk;

  calc_port_arbiter dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .req1_cmd_in   (cmd_in[0]),
    .req2_cmd_in   (cmd_in[1]),
    .req3_cmd_in   (cmd_in[2]),
    .req4_cmd_in   (cmd_in[3]),
    .req1_data_in  (data_in[0]),
    .req2_data_in  (data_in[1]),
    .req3_data_in  (data_in[2]),
    .req4_data_in  (data_in[3]),
    .out_data1     (out_data[0]),
    .out_data2     (out_data[1]),
    .out_data3     (out_data[2]),
    .out_data4     (out_data[3]),
    .out_resp1     (out_resp[0]),
    .out_resp2     (out_resp[1]),
    .out_resp3     (out_resp[2]),
    .out_resp4     (out_resp[3]),
    .alu_req_valid (alu_req_valid),
    .alu_req_ready (alu_req_ready),
    .alu_req_cmd   (alu_req_cmd),
    .alu_req_op1   (alu_req_op1),
    .alu_req_op2   (alu_req_op2),
    .alu_req_tag   (alu_req_tag),
    .alu_rsp_valid (alu_rsp_valid),
    .alu_rsp_tag   (alu_rsp_tag),
    .alu_rsp_resp  (alu_rsp_resp),
    .alu_rsp_data  (alu_rsp_data),
    .port_busy     (port_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  function automatic logic [31:0] alu_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      CMD_ADD: return a + b;
      CMD_SUB: return a - b;
      CMD_SHL: return a << b[4:0];
      CMD_SHR: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  // 1-cycle ALU: accepted at edge N, result strobe sampled at edge N+1.
  initial begin : alu_model
    logic          acc;
    logic [TW-1:0] a_tag;
    logic [31:0]   a_res;
    alu_rsp_valid = 1'b0;
    alu_rsp_tag   = '0;
    alu_rsp_resp  = 2'd0;
    alu_rsp_data  = '0;
    forever begin
      @(negedge c_clk);
      acc   = alu_req_valid && alu_req_ready && alu_en && !reset;
      a_tag = alu_req_tag;
      a_res = alu_calc(alu_req_cmd, alu_req_op1, alu_req_op2);
      @(posedge c_clk);
      #2;
      if (inj_valid) begin
        alu_rsp_valid = 1'b1;
        alu_rsp_tag   = inj_tag;
        alu_rsp_resp  = RESP_OK;
        alu_rsp_data  = inj_data;
      end else if (acc) begin
        alu_rsp_valid = 1'b1;
        alu_rsp_tag   = a_tag;
        alu_rsp_resp  = RESP_OK;
        alu_rsp_data  = a_res;
      end else begin
        alu_rsp_valid = 1'b0;
        alu_rsp_tag   = '0;
        alu_rsp_resp  = 2'd0;
        alu_rsp_data  = '0;
      end
    end
  end

  // Monitor: pops expected issues at acceptance and expected responses per port.
  initial begin : monitor
    int   idx;
    iss_t ei;
    forever begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        if (out_resp[p] != 2'd0) begin
          idx = -1;
          for (int i = 0; i < rsp_q.size(); i++)
            if (idx < 0 && rsp_q[i].port == p) idx = i;
          if (idx < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_resp port%0d: got resp=%0d data=0x%0h, required no response",
                     p + 1, out_resp[p], out_data[p]);
          end else begin
            check($sformatf("resp_code_p%0d", p + 1), 64'(out_resp[p]), 64'(rsp_q[idx].resp));
            check($sformatf("resp_data_p%0d", p + 1), 64'(out_data[p]), 64'(rsp_q[idx].data));
            rsp_q.delete(idx);
          end
        end
      end
      if (alu_req_valid && alu_req_ready) begin
        if (iss_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_issue: got tag=%0d cmd=%0d, required no issue", alu_req_tag, alu_req_cmd);
        end else begin
          ei = iss_q.pop_front();
          check("issue_cmd", 64'(alu_req_cmd), 64'(ei.cmd));
          check("issue_op1", 64'(alu_req_op1), 64'(ei.op1));
          check("issue_op2", 64'(alu_req_op2), 64'(ei.op2));
          check("issue_tag", 64'(alu_req_tag), 64'(ei.tag));
        end
      end
    end
  end

  task automatic exp_iss(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int tag);
    iss_t e;
    e.cmd = c; e.op1 = a; e.op2 = b; e.tag = TW'(tag);
    iss_q.push_back(e);
  endtask

  task automatic exp_rsp(input int p, input logic [1:0] r, input logic [31:0] d);
    rsp_t e;
    e.port = p; e.resp = r; e.data = d;
    rsp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || iss_q.size() != 0 || port_busy != 4'd0) && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d rsp / %0d iss outstanding busy=%b, required 0/0/0000",
               rsp_q.size(), iss_q.size(), port_busy);
    end
    tick();
  endtask

  initial begin : stim
    for (int p = 0; p < 4; p++) begin
      cmd_in[p]  = 4'd0;
      data_in[p] = '0;
    end
    alu_req_ready = 1'b1;
    alu_en        = 1'b1;
    inj_valid     = 1'b0;
    inj_tag       = '0;
    inj_data      = '0;
    reset         = 1'b1;
    #1;
    check("rst_valid", 64'(alu_req_valid), 64'd0);
    check("rst_busy",  64'(port_busy), 64'd0);
    check("rst_cmd",   64'(alu_req_cmd), 64'd0);
    check("rst_resp1", 64'(out_resp[0]), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // All four ports add in the same cycle: tags 0,1,2,3 on consecutive edges.
    for (int p = 0; p < 4; p++) begin
      cmd_in[p]  = CMD_ADD;
      data_in[p] = 32'(10 * (p + 1));
      exp_iss(CMD_ADD, 32'(10 * (p + 1)), 32'(p + 1), p);
      exp_rsp(p, RESP_OK, 32'(11 * (p + 1)));
    end
    tick();
    for (int p = 0; p < 4; p++) begin
      cmd_in[p]  = CMD_NOP;
      data_in[p] = 32'(p + 1);
    end
    check("all4_busy", 64'(port_busy), 64'hF);
    tick();
    for (int p = 0; p < 4; p++) data_in[p] = '0;
    for (int t = 0; t < 4; t++) begin
      check($sformatf("all4_tag_slot%0d", t), 64'(alu_req_tag), 64'(t));
      tick();
    end
    check("all4_valid_end", 64'(alu_req_valid), 64'd0);
    drain();

    // Pointer back at port 1: ports 2 and 4 together -> port 2 first.
    cmd_in[1] = CMD_SHL; data_in[1] = 32'h3;
    cmd_in[3] = CMD_SHR; data_in[3] = 32'h80;
    exp_iss(CMD_SHL, 32'h3, 32'h4, 1);
    exp_iss(CMD_SHR, 32'h80, 32'h3, 3);
    exp_rsp(1, RESP_OK, 32'h30);
    exp_rsp(3, RESP_OK, 32'h10);
    tick();
    cmd_in[1] = CMD_NOP; data_in[1] = 32'h4;
    cmd_in[3] = CMD_NOP; data_in[3] = 32'h3;
    tick();
    data_in[1] = '0; data_in[3] = '0;
    check("pair_first_tag", 64'(alu_req_tag), 64'd1);
    drain();

    // Port 1 add, latency 4 edges; port 3 invalid command lands in the same response cycle.
    cmd_in[0] = CMD_ADD; data_in[0] = 32'h1;
    exp_iss(CMD_ADD, 32'h1, 32'h1FFFFFF, 0);
    exp_rsp(0, RESP_OK, 32'h2000000);
    tick();                                   // E0
    cmd_in[0] = CMD_NOP; data_in[0] = 32'h1FFFFFF;
    check("lat_e0_resp1", 64'(out_resp[0]), 64'd0);
    tick();                                   // E1
    data_in[0] = '0;
    check("lat_e1_valid", 64'(alu_req_valid), 64'd1);
    cmd_in[2] = 4'd7; data_in[2] = 32'hABCD;
    exp_rsp(2, RESP_ERR, 32'h0);
    tick();                                   // E2
    cmd_in[2] = CMD_NOP; data_in[2] = 32'h1234;
    check("lat_e2_resp1", 64'(out_resp[0]), 64'd0);
    tick();                                   // E3
    data_in[2] = '0;
    check("lat_e3_resp1", 64'(out_resp[0]), 64'd1);
    check("lat_e3_resp3", 64'(out_resp[2]), 64'd2);
    tick();                                   // E4
    check("lat_e4_resp1", 64'(out_resp[0]), 64'd0);
    drain();

    // Port 3 invalid commands 3 then 4: no ALU traffic, resp=2 after each.
    cmd_in[2] = 4'd3; data_in[2] = 32'h11;
    exp_rsp(2, RESP_ERR, 32'h0);
    exp_rsp(2, RESP_ERR, 32'h0);
    tick();
    cmd_in[2] = CMD_NOP; data_in[2] = 32'h22;
    tick();
    check("inv3_resp", 64'(out_resp[2]), 64'd2);
    check("inv3_valid", 64'(alu_req_valid), 64'd0);
    tick();
    cmd_in[2] = 4'd4; data_in[2] = 32'h33;
    tick();
    cmd_in[2] = CMD_NOP; data_in[2] = 32'h44;
    tick();
    data_in[2] = '0;
    check("inv4_resp", 64'(out_resp[2]), 64'd2);
    check("inv4_valid", 64'(alu_req_valid), 64'd0);
    drain();

    // Ready held low for 5 cycles: port 2 request frozen, accepted once.
    alu_req_ready = 1'b0;
    cmd_in[1] = CMD_SUB; data_in[1] = 32'd100;
    exp_iss(CMD_SUB, 32'd100, 32'd30, 1);
    exp_rsp(1, RESP_OK, 32'd70);
    tick();
    cmd_in[1] = CMD_NOP; data_in[1] = 32'd30;
    tick();
    data_in[1] = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", 64'(alu_req_valid), 64'd1);
      check("hold_op1",   64'(alu_req_op1), 64'd100);
      check("hold_op2",   64'(alu_req_op2), 64'd30);
      check("hold_tag",   64'(alu_req_tag), 64'd1);
      tick();
    end
    data_in[1] = '0;
    alu_req_ready = 1'b1;
    drain();

    // Reset while port 4 is ISSUED; a late tag-3 result must be ignored.
    alu_en = 1'b0;
    cmd_in[3] = CMD_ADD; data_in[3] = 32'd5;
    exp_iss(CMD_ADD, 32'd5, 32'd6, 3);
    tick();
    cmd_in[3] = CMD_NOP; data_in[3] = 32'd6;
    tick();
    data_in[3] = '0;
    tick();
    check("rst_mid_busy_before", 64'(port_busy), 64'h8);
    reset = 1'b1;
    #1;
    check("rst_mid_busy",  64'(port_busy), 64'd0);
    check("rst_mid_valid", 64'(alu_req_valid), 64'd0);
    check("rst_mid_resp4", 64'(out_resp[3]), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    inj_valid = 1'b1; inj_tag = TW'(3); inj_data = 32'h55;
    tick();
    inj_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rst_late_resp4", 64'(out_resp[3]), 64'd0);
      tick();
    end
    check("rst_late_busy", 64'(port_busy), 64'd0);

`ifdef CALC_ARB_TIMEOUT_EN
    // ALU silent for port 1: timeout response 16 cycles after acceptance.
    cmd_in[0] = CMD_ADD; data_in[0] = 32'd1;
    exp_iss(CMD_ADD, 32'd1, 32'd2, 0);
    exp_rsp(0, RESP_TMO, 32'h0);
    tick();                                   // E0
    cmd_in[0] = CMD_NOP; data_in[0] = 32'd2;
    tick();                                   // E1
    data_in[0] = '0;
    tick();                                   // E2 accepted
    repeat (15) tick();
    check("tmo_before", 64'(out_resp[0]), 64'd0);
    tick();
    check("tmo_resp", 64'(out_resp[0]), 64'd3);
    tick();
    inj_valid = 1'b1; inj_tag = TW'(0); inj_data = 32'h77;
    tick();
    inj_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("tmo_stale_resp1", 64'(out_resp[0]), 64'd0);
      tick();
    end
`endif
    alu_en = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
